// File: rtl/fir_run_controller.sv
// Run sequencer for one FIR filter pass: clear, coefficient load, stream, drain, done.
// Also tracks output validity through the datapath latency and indexes valid outputs.
module fir_run_controller #(
    parameter int unsigned NumTaps    = 30,
    parameter int unsigned FirLatency = 2,
    parameter int unsigned Timeout    = 1024,
    parameter int unsigned IndexWidth = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  coeff_enable_o,
    input  logic                  coeff_set_flag_i,
    output logic                  data_enable_o,
    input  logic                  data_set_flag_i,
    output logic                  fir_clear_o,
    output logic                  fir_enable_o,
    output logic                  out_valid_o,
    output logic [IndexWidth-1:0] sample_index_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int unsigned WdW = (Timeout > 1) ? $clog2(Timeout) : 1;
    localparam int unsigned DrW = (NumTaps > 1) ? $clog2(NumTaps) : 1;
    localparam logic [WdW-1:0] WdMax = WdW'(Timeout - 1);
    localparam logic [DrW-1:0] DrainLoad = DrW'(NumTaps - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [WdW-1:0]          wd_q, wd_d;
    logic [DrW-1:0]          drain_q, drain_d;
    logic [FirLatency-1:0]   pipe_q, pipe_d;
    logic [IndexWidth-1:0]   idx_q, idx_d;
    logic                    err_q, err_d;
    logic                    start_run;
    logic                    flush;

    always_comb begin
        coeff_enable_o = 1'b0;
        data_enable_o  = 1'b0;
        fir_enable_o   = 1'b0;
        fir_clear_o    = 1'b0;
        done_o         = 1'b0;
        busy_o         = (state_q != StIdle);
        unique case (state_q)
            StClear:  fir_clear_o = 1'b1;
            StLoad:   coeff_enable_o = 1'b1;
            StStream: begin
                coeff_enable_o = 1'b1;
                data_enable_o  = 1'b1;
                fir_enable_o   = 1'b1;
            end
            StDrain: begin
                coeff_enable_o = 1'b1;
                fir_enable_o   = 1'b1;
            end
            StDone:   done_o = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        drain_d   = drain_q;
        err_d     = err_q;
        start_run = 1'b0;
        flush     = 1'b0;
        unique case (state_q)
            StIdle: begin
                wd_d = '0;
                if (start_i && !abort_i) begin
                    state_d   = StClear;
                    start_run = 1'b1;
                end
            end
            StClear: begin
                wd_d    = '0;
                state_d = StLoad;
            end
            StLoad: begin
                if (coeff_set_flag_i) begin
                    state_d = StStream;
                    wd_d    = '0;
                end else if (wd_q == WdMax) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StStream: begin
                // A completion flag takes priority over a simultaneous watchdog expiry.
                if (data_set_flag_i) begin
                    state_d = (NumTaps > 1) ? StDrain : StDone;
                    drain_d = DrainLoad;
                end else if (wd_q == WdMax) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StDrain: begin
                drain_d = drain_q - 1'b1;
                if (drain_q == DrW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            flush   = 1'b1;
        end
        if (start_run) begin
            err_d = 1'b0;
        end
    end

    always_comb begin
        pipe_d = (pipe_q << 1) | FirLatency'(fir_enable_o);
        idx_d  = idx_q;
        if (out_valid_o) begin
            idx_d = idx_q + 1'b1;
        end
        // Any leftover tail from a previous run is discarded when a new run starts.
        if (flush || start_run) begin
            pipe_d = '0;
        end
        if (start_run) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            wd_q    <= '0;
            drain_q <= '0;
            pipe_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            drain_q <= drain_d;
            pipe_q  <= pipe_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign out_valid_o    = pipe_q[FirLatency-1];
    assign sample_index_o = idx_q;
    assign error_o        = err_q;

endmodule

// File: tb/tb_fir_run_controller.sv
// Directed bench for fir_run_controller: a 30-tap default instance and a small
// instance (6 taps, timeout 16, 4-bit index) for watchdog and index wrap cases.
module tb_fir_run_controller;

    localparam int Lat = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        start_s [2];
    logic        abort_s [2];
    logic        rstn_s  [2];
    logic        cflag_s [2];
    logic        dflag_s [2];
    logic        ce_s    [2];
    logic        de_s    [2];
    logic        clr_s   [2];
    logic        fe_s    [2];
    logic        ov_s    [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        err_s   [2];
    logic [15:0] idx0_w;
    logic [3:0]  idx1_w;

    int checks = 0;
    int errors = 0;

    fir_run_controller #(
        .NumTaps(30), .FirLatency(Lat), .Timeout(1024), .IndexWidth(16)
    ) u_dut0 (
        .clock_i         (clk),
        .reset_n_i       (rstn_s[0]),
        .start_i         (start_s[0]),
        .abort_i         (abort_s[0]),
        .coeff_enable_o  (ce_s[0]),
        .coeff_set_flag_i(cflag_s[0]),
        .data_enable_o   (de_s[0]),
        .data_set_flag_i (dflag_s[0]),
        .fir_clear_o     (clr_s[0]),
        .fir_enable_o    (fe_s[0]),
        .out_valid_o     (ov_s[0]),
        .sample_index_o  (idx0_w),
        .busy_o          (busy_s[0]),
        .done_o          (done_s[0]),
        .error_o         (err_s[0])
    );

    fir_run_controller #(
        .NumTaps(6), .FirLatency(Lat), .Timeout(16), .IndexWidth(4)
    ) u_dut1 (
        .clock_i         (clk),
        .reset_n_i       (rstn_s[1]),
        .start_i         (start_s[1]),
        .abort_i         (abort_s[1]),
        .coeff_enable_o  (ce_s[1]),
        .coeff_set_flag_i(cflag_s[1]),
        .data_enable_o   (de_s[1]),
        .data_set_flag_i (dflag_s[1]),
        .fir_clear_o     (clr_s[1]),
        .fir_enable_o    (fe_s[1]),
        .out_valid_o     (ov_s[1]),
        .sample_index_o  (idx1_w),
        .busy_o          (busy_s[1]),
        .done_o          (done_s[1]),
        .error_o         (err_s[1])
    );

    function automatic logic [15:0] idx_of(input int sel);
        return (sel == 0) ? idx0_w : {12'd0, idx1_w};
    endfunction

    function automatic logic [7:0] outs_of(input int sel);
        return {ce_s[sel], de_s[sel], fe_s[sel], clr_s[sel],
                done_s[sel], busy_s[sel], ov_s[sel], err_s[sel]};
    endfunction

    // One run on instance sel; c_cyc == 0 means the loader never flags.
    // Vector order: {coeff_en, data_en, fir_en, fir_clear, done, busy, out_valid, error}.
    task automatic run(input int sel, input int c_cyc, input int s_cyc, input int abort_k,
                       input int rst_k, input int xs_k, input bit b2b,
                       input int exp_total, input int exp_last);
        int taps, tmo, mask, big, k_str0, k_drn0, k_done, k_to, k_end, j, st;
        int n_exp, n_obs, last_obs;
        logic e_ov, e_err;
        logic [7:0] expv, obs;
        big  = 1 << 30;
        taps = (sel == 0) ? 30 : 6;
        tmo  = (sel == 0) ? 1024 : 16;
        mask = (sel == 0) ? 32'hFFFF : 32'hF;
        if (c_cyc == 0) begin
            k_str0 = big; k_drn0 = big; k_done = big;
            k_to   = 2 + tmo;
            k_end  = k_to + 1;
        end else begin
            k_str0 = 2 + c_cyc;
            k_drn0 = k_str0 + s_cyc;
            k_done = k_drn0 + taps - 1;
            k_to   = big;
            k_end  = b2b ? k_done + 1 : k_done + Lat;
        end
        if (abort_k != 0) k_end = abort_k + 3;
        if (rst_k != 0) k_end = rst_k + 1;
        n_exp = 0; n_obs = 0; last_obs = -1;
        start_s[sel] = 1'b1;
        for (int k = 1; k <= k_end; k++) begin
            @(posedge clk);
            #1;
            if (rst_k != 0 && k == rst_k + 1) begin
                checks++;
                if ({outs_of(sel), idx_of(sel)} !== 24'd0) begin
                    errors++;
                    $display("FAIL reset_mid_run dut%0d: outs=%b idx=%0d, required all zero",
                             sel, outs_of(sel), idx_of(sel));
                end
                rstn_s[sel] = 1'b1;
                break;
            end
            if (abort_k != 0 && k > abort_k) st = 0;
            else if (k == 1) st = 1;
            else if (k < k_str0 && k < k_to) st = 2;
            else if (k >= k_str0 && k < k_drn0) st = 3;
            else if (k >= k_drn0 && k < k_done) st = 4;
            else if (k == k_done) st = 5;
            else st = 0;
            j     = k - Lat;
            e_ov  = !(abort_k != 0 && k > abort_k) && j >= k_str0 && j < k_done;
            e_err = (k >= k_to);
            expv  = {(st == 2 || st == 3 || st == 4), (st == 3), (st == 3 || st == 4),
                     (st == 1), (st == 5), (st != 0), e_ov, e_err};
            obs   = outs_of(sel);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL outputs dut%0d cycle %0d: got %b, required %b",
                         sel, k, obs, expv);
            end
            if (ov_s[sel] === 1'b1) begin
                n_obs++;
                last_obs = int'(idx_of(sel));
            end
            if (e_ov) begin
                checks++;
                if (idx_of(sel) !== 16'(n_exp & mask)) begin
                    errors++;
                    $display("FAIL sample_index dut%0d cycle %0d: got %0d, required %0d",
                             sel, k, idx_of(sel), n_exp & mask);
                end
                n_exp++;
            end
            start_s[sel] = (k == xs_k) || (b2b && k >= k_done);
            abort_s[sel] = (k == abort_k);
            rstn_s[sel]  = !(rst_k != 0 && k == rst_k);
            cflag_s[sel] = (k == k_str0 - 1);
            dflag_s[sel] = (k == k_drn0 - 1);
        end
        if (exp_total >= 0) begin
            checks++;
            if (n_obs != exp_total) begin
                errors++;
                $display("FAIL out_valid_count dut%0d: got %0d, required %0d",
                         sel, n_obs, exp_total);
            end
            checks++;
            if (last_obs != exp_last) begin
                errors++;
                $display("FAIL last_index dut%0d: got %0d, required %0d",
                         sel, last_obs, exp_last);
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            rstn_s[s] = 1'b0; start_s[s] = 1'b0; abort_s[s] = 1'b0;
            cflag_s[s] = 1'b0; dflag_s[s] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({outs_of(s), idx_of(s)} !== 24'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: outs=%b idx=%0d, required all zero",
                         s, outs_of(s), idx_of(s));
            end
            rstn_s[s] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_nominal();
        run(0, 30, 59, 0, 0, 0, 1'b0, 88, 87);
    endtask

    task automatic test_watchdog();
        run(1, 0, 0, 0, 0, 0, 1'b0, 0, -1);
        run(1, 3, 5, 0, 0, 0, 1'b0, 10, 9);
    endtask

    task automatic test_abort();
        run(0, 4, 40, 26, 0, 0, 1'b0, -1, -1);
        @(posedge clk);
        #1;
        checks++;
        if (outs_of(0) !== 8'd0) begin
            errors++;
            $display("FAIL abort_idle: outs=%b, required 00000000", outs_of(0));
        end
    endtask

    task automatic test_reset_drain();
        run(0, 4, 10, 0, 21, 0, 1'b0, -1, -1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_corner();
        run(0, 4, 10, 0, 0, 9, 1'b0, 39, 38);
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        checks++;
        if ({busy_s[0], clr_s[0]} !== 2'b00) begin
            errors++;
            $display("FAIL start_with_abort: busy,clear=%b, required 00", {busy_s[0], clr_s[0]});
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_with_abort_hold: busy=%b, required 0", busy_s[0]);
        end
    endtask

    task automatic test_back_to_back();
        run(0, 4, 10, 0, 0, 0, 1'b1, 39, 38);
        run(0, 5, 8, 0, 0, 0, 1'b0, 37, 36);
    endtask

    task automatic test_wrap();
        run(1, 3, 15, 0, 0, 0, 1'b0, 20, 3);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_watchdog();
        test_abort();
        test_reset_drain();
        test_corner();
        test_back_to_back();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
